// File: rtl/plru_way_select_pkg.sv
// Shared cache parameters and the init/ready state encoding for the PLRU way selector.
package plru_way_select_pkg;

    localparam int PLRU_WAYS = 8;
    localparam int PLRU_SETS = 256;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } plru_state_e;

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU helper: victim search and path update over a heap-indexed tree.
module plru_tree #(
    parameter int WAYS = 8
) (
    input  logic [WAYS-2:0]         bits_i,
    input  logic [$clog2(WAYS)-1:0] way_i,
    output logic [$clog2(WAYS)-1:0] victim_o,
    output logic [WAYS-2:0]         bits_o
);

    localparam int LW = $clog2(WAYS);

    logic [LW-1:0] vnode;
    logic [LW-1:0] unode;
    logic          dir;

    // Victim walk: a 0 bit steers to the lower half, so the bit itself is the next way-index bit.
    always_comb begin
        victim_o = '0;
        vnode    = '0;
        for (int l = 0; l < LW; l++) begin
            victim_o = LW'((int'(victim_o) << 1) | int'(bits_i[vnode]));
            vnode    = LW'(2 * int'(vnode) + 1 + int'(bits_i[vnode]));
        end
    end

    // Path update: each node on the way's path is flipped to point at the other half.
    always_comb begin
        bits_o = bits_i;
        unode  = '0;
        dir    = 1'b0;
        for (int l = 0; l < LW; l++) begin
            dir           = |(way_i & (LW'(1) << (LW - 1 - l)));
            bits_o[unode] = ~dir;
            unode         = LW'(2 * int'(unode) + 1 + int'(dir));
        end
    end

endmodule

// File: rtl/plru_way_select.sv
// Per-set tree-PLRU way selector: hit priority, then invalid fill, then PLRU victim.
module plru_way_select
    import plru_way_select_pkg::*;
#(
    parameter int WAYS = PLRU_WAYS,
    parameter int SETS = PLRU_SETS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [$clog2(SETS)-1:0] set_index,
    input  logic [WAYS-1:0]         hit_vec,
    input  logic [WAYS-1:0]         valid_vec,
    output logic                    sel_valid,
    output logic [$clog2(WAYS)-1:0] select,
    output logic                    hit,
    output logic                    multi_hit
);

    localparam int LW = $clog2(WAYS);
    localparam int IW = $clog2(SETS);

    plru_state_e   state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;

    logic [WAYS-2:0] plru_q [SETS];
    logic [WAYS-2:0] cur_bits;
    logic [WAYS-2:0] upd_bits;
    logic [LW-1:0]   victim;

    logic          accept;
    logic          hit_any;
    logic          all_valid;
    logic          multi_d;
    logic [LW-1:0] hit_idx;
    logic [LW-1:0] inv_idx;
    logic [LW-1:0] sel_d;

    logic          sel_valid_q;
    logic [LW-1:0] select_q;
    logic          hit_q;
    logic          multi_q;

    assign req_ready = (state_q == ST_READY);
    assign accept    = req_ready && req_valid && !reset;
    assign cur_bits  = plru_q[set_index];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IW'(SETS - 1)) state_d = ST_READY;
            end
            ST_READY: ;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Priority pick; downward loops leave the lowest set index as the final assignment.
    always_comb begin
        hit_any   = |hit_vec;
        all_valid = &valid_vec;
        multi_d   = |(hit_vec & (hit_vec - WAYS'(1)));
        hit_idx   = '0;
        inv_idx   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i])    hit_idx = LW'(i);
            if (!valid_vec[i]) inv_idx = LW'(i);
        end
        if (hit_any)         sel_d = hit_idx;
        else if (!all_valid) sel_d = inv_idx;
        else                 sel_d = victim;
    end

    plru_tree #(.WAYS(WAYS)) u_tree (
        .bits_i   (cur_bits),
        .way_i    (sel_d),
        .victim_o (victim),
        .bits_o   (upd_bits)
    );

    // PLRU storage has no reset; the init sweep is the only thing that defines it.
    always_ff @(posedge clk) begin
        if (!reset && state_q == ST_INIT)
            plru_q[cnt_q] <= '0;
        else if (accept)
            plru_q[set_index] <= upd_bits;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_valid_q <= 1'b0;
            select_q    <= '0;
            hit_q       <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            sel_valid_q <= accept;
            if (accept) begin
                select_q <= sel_d;
                hit_q    <= hit_any;
                multi_q  <= multi_d;
            end
        end
    end

    assign sel_valid = sel_valid_q;
    assign select    = select_q;
    assign hit       = hit_q;
    assign multi_hit = multi_q;

endmodule

// File: tb/tb_plru_way_select.sv
// Directed + randomized scoreboard bench for the PLRU way selector (8 ways, 256 sets).
module tb_plru_way_select;

    localparam int WAYS = 8;
    localparam int SETS = 256;
    localparam int LW   = 3;
    localparam int IW   = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [IW-1:0]   set_index;
    logic [WAYS-1:0] hit_vec;
    logic [WAYS-1:0] valid_vec;
    logic            sel_valid;
    logic [LW-1:0]   select;
    logic            hit;
    logic            multi_hit;

    plru_way_select #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .set_index (set_index),
        .hit_vec   (hit_vec),
        .valid_vec (valid_vec),
        .sel_valid (sel_valid),
        .select    (select),
        .hit       (hit),
        .multi_hit (multi_hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LW-1:0] sel;
        logic          hit;
        logic          multi;
    } exp_t;

    exp_t            sb_q[$];
    int              checks = 0;
    int              errors = 0;
    logic [WAYS-2:0] mdl [SETS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: range-bisection walk over the per-set tree bits.
    task automatic model_pick(input logic [IW-1:0] s, input logic [WAYS-1:0] h,
                              input logic [WAYS-1:0] v, output exp_t e);
        int sel, lo, span, n;
        sel = -1;
        for (int i = 0; i < WAYS; i++) if (sel < 0 && h[i]) sel = i;
        if (sel < 0) for (int i = 0; i < WAYS; i++) if (sel < 0 && !v[i]) sel = i;
        if (sel < 0) begin
            lo = 0; span = WAYS; n = 0;
            while (span > 1) begin
                span = span / 2;
                if (mdl[s][n]) begin lo = lo + span; n = 2 * n + 2; end
                else n = 2 * n + 1;
            end
            sel = lo;
        end
        lo = 0; span = WAYS; n = 0;
        while (span > 1) begin
            span = span / 2;
            if (sel >= lo + span) begin mdl[s][n] = 1'b0; lo = lo + span; n = 2 * n + 2; end
            else begin mdl[s][n] = 1'b1; n = 2 * n + 1; end
        end
        e.sel   = LW'(sel);
        e.hit   = (h != 0);
        e.multi = ($countones(h) > 1);
    endtask

    // One accepted request; exp_sel >= 0 overrides the model's select with a directed constant.
    task automatic step(input logic [IW-1:0] s, input logic [WAYS-1:0] h,
                        input logic [WAYS-1:0] v, input int exp_sel);
        exp_t e;
        model_pick(s, h, v, e);
        if (exp_sel >= 0) e.sel = LW'(exp_sel);
        sb_q.push_back(e);
        set_index = s; hit_vec = h; valid_vec = v; req_valid = 1'b1;
        @(posedge clk); #1;
        chk("sel_valid", 32'(sel_valid), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("select", 32'(select), 32'(e.sel));
            chk("hit", 32'(hit), 32'(e.hit));
            chk("multi_hit", 32'(multi_hit), 32'(e.multi));
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("sel_valid_idle", 32'(sel_valid), 32'd0);
    endtask

    // Counts cycles with req_ready low; keeps a request asserted to show it is ignored.
    task automatic init_wait();
        int cnt;
        logic saw_sel;
        cnt = 0; saw_sel = 1'b0;
        set_index = 8'd5; hit_vec = '0; valid_vec = '1; req_valid = 1'b1;
        while (!req_ready && cnt < 2000) begin
            @(posedge clk); #1;
            cnt++;
            if (sel_valid) saw_sel = 1'b1;
        end
        req_valid = 1'b0;
        chk("init_cycles", 32'(cnt), 32'd256);
        chk("init_no_sel_valid", 32'(saw_sel), 32'd0);
        chk("ready_after_init", 32'(req_ready), 32'd1);
        for (int i = 0; i < SETS; i++) mdl[i] = '0;
    endtask

    initial begin
        int sel_seq[9];
        logic [IW-1:0]   s;
        logic [WAYS-1:0] h, v;
        int r;
        sel_seq = '{0, 4, 2, 6, 1, 5, 3, 7, 0};

        reset = 1'b1; req_valid = 1'b0; set_index = '0; hit_vec = '0; valid_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel_valid", 32'(sel_valid), 32'd0);
        chk("rst_select", 32'(select), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_multi", 32'(multi_hit), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        init_wait();

        // Repeated all-valid misses walk the full PLRU order on one set.
        for (int i = 0; i < 9; i++) step(8'd5, 8'h00, 8'hff, sel_seq[i]);
        idle();
        step(8'd7, 8'b0010_0100, 8'hff, 2);
        idle();
        step(8'd7, 8'b1000_0000, 8'hff, 7);
        step(8'd5, 8'h00, 8'b1110_1111, 4);
        step(8'd3, 8'h00, 8'hff, 0);
        step(8'd9, 8'h00, 8'hff, 0);
        step(8'd3, 8'h00, 8'hff, 4);
        idle();

        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 3);
            s = (r == 3) ? 8'd255 : IW'(r);
            r = $urandom_range(0, 3);
            h = (r == 1) ? WAYS'(1 << $urandom_range(0, WAYS - 1)) :
                (r == 2) ? WAYS'($urandom) : '0;
            v = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : 8'hff;
            step(s, h, v, -1);
            if (k % 7 == 6) idle();
        end

        // Reset in READY with one result just delivered and another request presented.
        repeat (10) idle();
        step(8'd20, 8'h00, 8'hff, 0);
        set_index = 8'd20; hit_vec = 8'h03; valid_vec = 8'hff; req_valid = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_sel_valid", 32'(sel_valid), 32'd0);
        chk("abort_select", 32'(select), 32'd0);
        chk("abort_hit", 32'(hit), 32'd0);
        chk("abort_multi", 32'(multi_hit), 32'd0);
        reset = 1'b0;
        init_wait();
        step(8'd5, 8'h00, 8'hff, 0);
        step(8'd5, 8'h00, 8'hff, 4);
        step(8'd20, 8'h00, 8'hff, 0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/plru_way_select.md
PLRU_WAY_SELECT -- requirements
Module: plru_way_select

Interface
REQ-001 The parameter WAYS SHALL default to 8 and is the associativity; it must be a power of two and at least 2.
REQ-002 The parameter SETS SHALL default to 256 and is the number of sets; it must be a power of two.
REQ-003 Port clk SHALL be a 1-bit input and is the single clock; every register updates on its rising edge.
REQ-004 Port reset SHALL be a 1-bit input; reset is synchronous and active-high.
REQ-005 Port req_valid SHALL be a 1-bit input indicating a lookup result is presented.
REQ-006 Port req_ready SHALL be a 1-bit output indicating the block accepts a request this cycle.
REQ-007 Port set_index SHALL be an input of width $clog2(SETS) carrying the set being accessed.
REQ-008 Port hit_vec SHALL be an input of width WAYS carrying per-way tag-match bits.
REQ-009 Port valid_vec SHALL be an input of width WAYS carrying per-way line-valid bits.
REQ-010 Port sel_valid SHALL be a 1-bit output indicating select, hit and multi_hit are valid.
REQ-011 Port select SHALL be an output of width $clog2(WAYS) carrying the way index that drives the downstream data multiplexor.
REQ-012 Port hit SHALL be a 1-bit output that is 1 when the selected way is a tag hit.
REQ-013 Port multi_hit SHALL be a 1-bit output that flags more than one bit set in hit_vec.

Function
REQ-014 The FSM SHALL have exactly two states: INIT and READY.
REQ-015 In INIT, a set counter SHALL step 0..SETS-1, clearing that set's WAYS-1 PLRU bits each cycle, with req_ready=0.
REQ-016 After clearing set SETS-1, the FSM SHALL enter READY on the next edge; INIT therefore lasts exactly SETS cycles.
REQ-017 In READY, req_ready SHALL be 1 and a request SHALL be accepted on any edge where req_valid=1.
REQ-018 Outputs SHALL be registered with latency 1: sel_valid is 1 in the cycle after acceptance and 0 otherwise.
REQ-019 On a hit (hit_vec != 0), select SHALL be the lowest-index set bit of hit_vec, and hit SHALL be 1.
REQ-020 multi_hit SHALL be 1 when popcount(hit_vec) > 1; the lowest-index rule of REQ-019 still applies.
REQ-021 On a miss with any valid_vec bit 0, select SHALL be the lowest-index invalid way, and hit SHALL be 0.
REQ-022 On a miss with all ways valid, select SHALL be the PLRU victim, and hit SHALL be 0.
REQ-023 The PLRU tree SHALL be indexed heap-style: node 0 is the root and node n has children 2n+1 and 2n+2.
REQ-024 For victim search, a PLRU bit of 0 SHALL mean descend toward the lower-index half and 1 toward the upper half.
REQ-025 On every accepted request, each tree bit on the path to the selected way SHALL be set to point away from it; off-path bits are unchanged.
REQ-026 The PLRU update SHALL be written on the acceptance edge, so a back-to-back request to the same set sees the updated state.
REQ-027 Requests to different sets SHALL never disturb each other's PLRU bits.
REQ-028 Inputs presented while req_ready=0 SHALL be ignored, with no state change.

Reset
REQ-029 When reset=1, the FSM SHALL go to INIT, the counter to 0, and sel_valid, select, hit and multi_hit to 0.
REQ-030 Reset asserted mid-INIT or mid-READY SHALL abort any in-flight result (sel_valid=0 next cycle) and restart the full sweep.
REQ-031 PLRU array contents SHALL be defined only by the INIT sweep, not by the reset itself.

Structure
REQ-032 The WAYS and SETS defaults and the INIT/READY state encoding SHALL live in the shared cache package.
REQ-033 Victim computation and path-update logic SHALL be a combinational sub-module named plru_tree, parameterised by WAYS.

Verification
REQ-034 Scenario: reset, then count cycles -> req_ready=0 for exactly 256 cycles, then 1.
REQ-035 Scenario: set 5 with all valid and no hit, repeated -> select = 0, 4, 2, 6, 1, 5, 3, 7, 0 (8-way).
REQ-036 Scenario: hit_vec=8'b0010_0100 -> select=2, hit=1, multi_hit=1, sel_valid exactly one cycle later.
REQ-037 Scenario: miss with valid_vec=8'b1110_1111 -> select=4 and hit=0, regardless of PLRU state.
REQ-038 Scenario: miss set 3 (victim 0), then miss set 9 -> set 9 victim is still 0; a following miss on set 3 gives 4.
REQ-039 Scenario: reset asserted at READY cycle 10 with a request in flight -> sel_valid=0 next cycle and a fresh 256-cycle INIT.
